// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit. It runs shift-add multiply or restoring
// divide, then writes the low and high result bytes to consecutive registers.
module muldiv_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SEL_W-1:0] dst,
    output logic             busy,
    output logic             wr_en,
    output logic [SEL_W-1:0] wr_sel,
    output logic [WIDTH-1:0] wr_data,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, WR_LO, WR_HI} state_t;

    state_t           state;
    logic [WIDTH-1:0] lo, hi, b_reg;
    logic             op_reg;
    logic [SEL_W-1:0] dst_reg;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] lo_nx, hi_nx;
    logic [WIDTH:0]   sum, rem_sh;

    // Multiply uses hi:lo as the accumulator with the multiplier in lo.
    // Divide uses hi as the remainder and lo as the dividend/quotient.
    always_comb begin
        lo_nx  = lo;
        hi_nx  = hi;
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        if (op_reg) begin
            if (rem_sh >= {1'b0, b_reg}) begin
                hi_nx = WIDTH'(rem_sh - {1'b0, b_reg});
                lo_nx = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = rem_sh[WIDTH-1:0];
                lo_nx = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lo      <= '0;
            hi      <= '0;
            b_reg   <= '0;
            op_reg  <= 1'b0;
            dst_reg <= '0;
            count   <= '0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
            dz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (start) begin
                        op_reg  <= op;
                        b_reg   <= b_in;
                        dst_reg <= dst;
                        count   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        if (op && (b_in == '0)) begin
                            dz    <= 1'b1;
                            lo    <= '1;
                            hi    <= a_in;
                            state <= WR_LO;
                        end else begin
                            dz    <= 1'b0;
                            lo    <= a_in;
                            hi    <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    wr_en <= 1'b0;
                    lo    <= lo_nx;
                    hi    <= hi_nx;
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= WR_LO;
                end
                WR_LO: begin
                    wr_en   <= 1'b1;
                    wr_sel  <= dst_reg;
                    wr_data <= lo;
                    state   <= WR_HI;
                end
                WR_HI: begin
                    wr_en   <= 1'b1;
                    wr_sel  <= dst_reg + 1'b1;
                    wr_data <= hi;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq. It runs directed and random operations against
// a plain-arithmetic model of the results, the write timing and the flags.
module tb_muldiv_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic [7:0] a_in, b_in;
    logic [2:0] dst;
    logic       busy, wr_en, dz;
    logic [2:0] wr_sel;
    logic [7:0] wr_data;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_seq #(.WIDTH(8), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .dst(dst),
        .busy(busy), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        op   = 1'($urandom);
        dst  = 3'($urandom);
    endtask

    // Issue one operation at the current negedge and check every cycle through the
    // second write. The call returns in the first idle cycle so that a following
    // call re-issues start immediately.
    task automatic run_op(input bit o, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] d, input int glitch_k);
        logic [15:0] p;
        logic [7:0]  lo_e, hi_e;
        logic [2:0]  d1;
        bit          dz_e;
        int          wl, busy_cnt;
        dz_e = o && (b == 8'd0);
        if (!o) begin
            p    = 16'(a) * 16'(b);
            lo_e = p[7:0];
            hi_e = p[15:8];
        end else if (b == 8'd0) begin
            lo_e = 8'hFF;
            hi_e = a;
        end else begin
            lo_e = a / b;
            hi_e = a % b;
        end
        d1 = d + 3'd1;
        wl = dz_e ? 1 : 9;
        busy_cnt = 0;
        start = 1'b1; op = o; a_in = a; b_in = b; dst = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        for (int k = 0; k <= wl + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            chk($sformatf("busy k=%0d", k), 32'(busy), 32'(k <= wl));
            chk($sformatf("wr_en k=%0d", k), 32'(wr_en), 32'(k == wl || k == wl + 1));
            chk($sformatf("dz k=%0d", k), 32'(dz), 32'(dz_e));
            if (k == wl) begin
                chk("wr_sel lo", 32'(wr_sel), 32'(d));
                chk("wr_data lo", 32'(wr_data), 32'(lo_e));
            end else if (k == wl + 1) begin
                chk("wr_sel hi", 32'(wr_sel), 32'(d1));
                chk("wr_data hi", 32'(wr_data), 32'(hi_e));
            end
            scramble_inputs();
            start = (k == glitch_k) && (k < wl);
        end
        start = 1'b0;
        chk("busy cycles", 32'(busy_cnt), 32'(wl + 1));
    endtask

    initial begin
        int wr_seen;
        bit ro;
        logic [7:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0; dst = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_sel", 32'(wr_sel), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        chk("reset dz", 32'(dz), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 8'd13, 8'd11, 3'd2, -1);
        run_op(1'b0, 8'hFF, 8'hFF, 3'd4, -1);
        run_op(1'b1, 8'd200, 8'd7, 3'd0, -1);
        run_op(1'b1, 8'h55, 8'h00, 3'd7, -1);
        repeat (4) @(negedge clk);
        chk("dz held while idle", 32'(dz), 32'd1);

        // Start pulse at T+3 with different operands must be ignored.
        run_op(1'b0, 8'd100, 8'd37, 3'd5, 2);
        run_op(1'b1, 8'd250, 8'd9, 3'd6, 5);

        // Reset asserted while the operation is still computing.
        start = 1'b1; op = 1'b0; a_in = 8'd77; b_in = 8'd91; dst = 3'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("busy after mid-op reset", 32'(busy), 32'd0);
        chk("wr_en after mid-op reset", 32'(wr_en), 32'd0);
        reset = 1'b0;
        wr_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || busy !== 1'b0) wr_seen++;
        end
        chk("no write after reset", 32'(wr_seen), 32'd0);
        run_op(1'b0, 8'd3, 8'd5, 3'd3, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            run_op(ro, ra, rb, 3'($urandom),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1);
        end

        repeat (3) @(negedge clk);
        chk("final wr_en", 32'(wr_en), 32'd0);
        chk("final busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
